flash_rom_loader: RTL and testbench

- Boot-time copier between the DSPI flash reader and the system RAM port.
- After reset it waits for the flash reader's ready, then reads LENGTH bytes starting at FLASH_BASE one byte at a time over the reader's cs/busy/dout interface.
- Each byte is written to RAM at RAM_BASE+offset through a simple we/ready handshake.
- Holds the VIC-20 core in reset (sys_resetn low) until the copy completes, so BASIC, KERNAL and character ROM images are in RAM before the CPU runs.

---
 rtl/flash_pkg.sv | 26 ++
 rtl/loader_timeout.sv | 28 ++
 rtl/flash_rom_loader.sv | 173 +++++++++++++++++
 tb/tb_flash_rom_loader.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// Shared definitions for the boot ROM loader: loader FSM states, flash address width
// and the default ROM image placement used by the core's memory map.
package flash_pkg;

    localparam int unsigned FLASH_AW = 24;

    typedef enum logic [2:0] {
        StWaitRdy,
        StGap,
        StReq,
        StWaitData,
        StLatch,
        StWrite,
        StDone,
        StFail
    } loader_state_e;

    localparam int unsigned BASIC_LEN  = 8192;
    localparam int unsigned KERNAL_LEN = 8192;
    localparam int unsigned CHAR_LEN   = 4096;

    localparam logic [FLASH_AW-1:0] DEFAULT_FLASH_BASE = 24'h200000;
    localparam logic [15:0]         DEFAULT_RAM_BASE   = 16'h0000;
    localparam int unsigned         DEFAULT_LENGTH     = BASIC_LEN + KERNAL_LEN + CHAR_LEN;

endpackage

// File: rtl/loader_timeout.sv
// Loadable down-counter used to bound the flash reader handshake; expired is high
// while the count sits at zero.
module loader_timeout #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             dec,
    output logic             expired
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - Width'(1);
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/flash_rom_loader.sv
// Boot-time copier: pulls LENGTH bytes from the flash reader into RAM and holds the
// core in reset until the whole image has landed.
module flash_rom_loader
    import flash_pkg::*;
#(
    parameter logic [FLASH_AW-1:0] FLASH_BASE = DEFAULT_FLASH_BASE,
    parameter int unsigned         RAM_AW     = 16,
    parameter logic [RAM_AW-1:0]   RAM_BASE   = RAM_AW'(DEFAULT_RAM_BASE),
    parameter int unsigned         LENGTH     = DEFAULT_LENGTH,
    parameter int unsigned         TMO_START  = 15,
    parameter int unsigned         TMO_DATA   = 63
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                flash_ready,
    input  logic                flash_busy,
    input  logic [7:0]          flash_dout,
    output logic                flash_cs,
    output logic [FLASH_AW-1:0] flash_addr,
    output logic [RAM_AW-1:0]   ram_addr,
    output logic [7:0]          ram_din,
    output logic                ram_we,
    input  logic                ram_ready,
    output logic                done,
    output logic                error,
    output logic                sys_resetn
);

    localparam int unsigned OffW   = $clog2(LENGTH + 1);
    localparam int unsigned TmoMax = (TMO_START > TMO_DATA) ? TMO_START : TMO_DATA;
    localparam int unsigned TmoW   = $clog2(TmoMax + 1);
    localparam logic [OffW-1:0] OffLast = OffW'(LENGTH - 1);

    loader_state_e       state_q, state_d;
    logic                gap_q, gap_d;
    logic [OffW-1:0]     off_q, off_d;
    logic [FLASH_AW-1:0] faddr_q, faddr_d;
    logic [RAM_AW-1:0]   raddr_q, raddr_d;
    logic [7:0]          rdin_q, rdin_d;
    logic                we_q, we_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                cs_q;
    logic                sysrst_q;

    logic                tmo_load, tmo_dec, tmo_expired;
    logic [TmoW-1:0]     tmo_val;

    loader_timeout #(
        .Width (TmoW)
    ) u_timeout (
        .clk      (clk),
        .resetn   (resetn),
        .load     (tmo_load),
        .load_val (tmo_val),
        .dec      (tmo_dec),
        .expired  (tmo_expired)
    );

    always_comb begin
        state_d  = state_q;
        gap_d    = 1'b0;
        off_d    = off_q;
        faddr_d  = faddr_q;
        raddr_d  = raddr_q;
        rdin_d   = rdin_q;
        we_d     = we_q;
        done_d   = done_q;
        err_d    = err_q;
        tmo_load = 1'b0;
        tmo_dec  = 1'b0;
        tmo_val  = '0;

        unique case (state_q)
            StWaitRdy: begin
                if (flash_ready) state_d = StGap;
            end
            // Two idle cycles with cs low so the reader's edge detector re-arms.
            StGap: begin
                if (gap_q) begin
                    state_d  = StReq;
                    tmo_load = 1'b1;
                    tmo_val  = TmoW'(TMO_START - 1);
                end else begin
                    gap_d = 1'b1;
                end
            end
            StReq: begin
                if (flash_busy) begin
                    state_d  = StWaitData;
                    tmo_load = 1'b1;
                    tmo_val  = TmoW'(TMO_DATA - 1);
                end else if (tmo_expired) begin
                    state_d = StFail;
                    err_d   = 1'b1;
                end else begin
                    tmo_dec = 1'b1;
                end
            end
            StWaitData: begin
                if (!flash_busy) begin
                    state_d = StLatch;
                end else if (tmo_expired) begin
                    state_d = StFail;
                    err_d   = 1'b1;
                end else begin
                    tmo_dec = 1'b1;
                end
            end
            // dout is only guaranteed one cycle after busy falls, hence this extra state.
            StLatch: begin
                rdin_d  = flash_dout;
                raddr_d = RAM_BASE + RAM_AW'(off_q);
                we_d    = 1'b1;
                state_d = StWrite;
            end
            StWrite: begin
                if (ram_ready) begin
                    we_d = 1'b0;
                    if (off_q == OffLast) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        off_d   = off_q + OffW'(1);
                        faddr_d = FLASH_BASE + FLASH_AW'(off_d);
                        state_d = StGap;
                    end
                end
            end
            StDone, StFail: begin
            end
            default: state_d = StFail;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StWaitRdy;
            gap_q    <= 1'b0;
            off_q    <= '0;
            faddr_q  <= FLASH_BASE;
            raddr_q  <= RAM_BASE;
            rdin_q   <= '0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cs_q     <= 1'b0;
            sysrst_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            off_q    <= off_d;
            faddr_q  <= faddr_d;
            raddr_q  <= raddr_d;
            rdin_q   <= rdin_d;
            we_q     <= we_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cs_q     <= (state_d == StReq);
            sysrst_q <= done_q;
        end
    end

    assign flash_cs   = cs_q;
    assign flash_addr = faddr_q;
    assign ram_addr   = raddr_q;
    assign ram_din    = rdin_q;
    assign ram_we     = we_q;
    assign done       = done_q;
    assign error      = err_q;
    assign sys_resetn = sysrst_q;

endmodule

// File: tb/tb_flash_rom_loader.sv
// Self-checking bench for flash_rom_loader: behavioural flash reader, RAM scoreboard
// and protocol monitors, driven by a linear sequence of directed/randomised steps.
module tb_flash_rom_loader;

    localparam logic [23:0] FB  = 24'hFFFFFA;   // flash image straddles the 2^24 wrap
    localparam logic [15:0] RB  = 16'hFFFC;     // RAM destination straddles the 2^16 wrap
    localparam int unsigned LEN = 8;
    localparam logic [15:0] RB2 = 16'hFFFE;     // RAM address of byte 2

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        flash_ready = 1'b0;
    logic        flash_busy;
    logic [7:0]  flash_dout;
    logic        flash_cs;
    logic [23:0] flash_addr;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic        ram_ready = 1'b1;
    logic        done, error, sys_resetn;

    int n_cmp = 0;
    int n_bad = 0;

    bit never_busy = 1'b0;
    int xfer_min = 1;
    int xfer_max = 12;
    bit rand_ready = 1'b0;
    bit stall_b2 = 1'b0;
    int stall_n = 0;
    int we_b2_cycles = 0;

    logic [15:0] wa_q[$];
    logic [7:0]  wd_q[$];
    logic [23:0] req_q[$];

    flash_rom_loader #(
        .FLASH_BASE (FB),
        .RAM_AW     (16),
        .RAM_BASE   (RB),
        .LENGTH     (LEN),
        .TMO_START  (15),
        .TMO_DATA   (63)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flash_ready (flash_ready),
        .flash_busy  (flash_busy),
        .flash_dout  (flash_dout),
        .flash_cs    (flash_cs),
        .flash_addr  (flash_addr),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_we      (ram_we),
        .ram_ready   (ram_ready),
        .done        (done),
        .error       (error),
        .sys_resetn  (sys_resetn)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Flash reader: two-flop cs sync + edge detect, random transfer length, dout valid
    // only from the cycle after busy falls (deliberately wrong while busy is low at first).
    logic s1, s2, s3, pend;
    int   xcnt;
    logic [23:0] lat;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0;
            flash_busy <= 1'b0; pend <= 1'b0; xcnt <= 0;
            flash_dout <= 8'h00; lat <= '0;
        end else begin
            s1 <= flash_cs; s2 <= s1; s3 <= s2;
            if (s2 && !s3 && !never_busy) begin
                flash_busy <= 1'b1;
                xcnt       <= int'($urandom_range(xfer_max, xfer_min));
                lat        <= flash_addr;
                req_q.push_back(flash_addr);
                flash_dout <= ~(flash_addr[7:0] ^ 8'hA5);
            end else if (flash_busy) begin
                if (xcnt <= 1) begin
                    flash_busy <= 1'b0;
                    pend       <= 1'b1;
                end
                xcnt <= xcnt - 1;
            end else if (pend) begin
                flash_dout <= lat[7:0] ^ 8'hA5;
                pend       <= 1'b0;
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (stall_b2 && ram_we && ram_addr == RB2 && stall_n < 5) begin
            ram_ready = 1'b0;
            stall_n++;
        end else if (rand_ready) begin
            ram_ready = ($urandom_range(3, 0) != 0);
        end else begin
            ram_ready = 1'b1;
        end
    end

    // Protocol monitors and write capture, sampled on the falling edge.
    logic        p_cs, p_busy, p_we, p_rdy;
    logic [23:0] p_fa;
    logic [15:0] p_ra;
    logic [7:0]  p_rd;
    int          low_run;
    bit          seen_rise;
    always @(negedge clk) begin
        if (!resetn) begin
            p_cs <= 1'b0; p_busy <= 1'b0; p_we <= 1'b0; p_rdy <= 1'b1;
            low_run <= 0; seen_rise <= 1'b0;
        end else begin
            if (flash_cs && !p_cs) begin
                if (seen_rise) check("cs_gap_ge2", 32'(low_run >= 2), 1);
                seen_rise <= 1'b1;
            end
            low_run <= flash_cs ? 0 : low_run + 1;
            if ((p_cs || p_busy) && (flash_cs || flash_busy))
                check("faddr_stable", 32'(flash_addr), 32'(p_fa));
            if (p_we && !p_rdy) begin
                check("stall_we", 32'(ram_we), 1);
                check("stall_addr", 32'(ram_addr), 32'(p_ra));
                check("stall_din", 32'(ram_din), 32'(p_rd));
            end
            if (ram_we) check("no_cs_while_we", 32'(flash_cs), 0);
            if (ram_we && ram_addr == RB2) we_b2_cycles = we_b2_cycles + 1;
            if (ram_we && ram_ready) begin
                wa_q.push_back(ram_addr);
                wd_q.push_back(ram_din);
            end
            p_cs <= flash_cs; p_busy <= flash_busy; p_we <= ram_we; p_rdy <= ram_ready;
            p_fa <= flash_addr; p_ra <= ram_addr; p_rd <= ram_din;
        end
    end

    task automatic clear_sb();
        wa_q.delete(); wd_q.delete(); req_q.delete();
        we_b2_cycles = 0;
        stall_n = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cs"}, 32'(flash_cs), 0);
        check({tag, "_faddr"}, 32'(flash_addr), 32'(FB));
        check({tag, "_raddr"}, 32'(ram_addr), 32'(RB));
        check({tag, "_rdin"}, 32'(ram_din), 0);
        check({tag, "_we"}, 32'(ram_we), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_error"}, 32'(error), 0);
        check({tag, "_sysrst"}, 32'(sys_resetn), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        resetn = 1'b0;
        clear_sb();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    // Waits for done/error; on done also checks that sys_resetn trails done by one cycle.
    task automatic run_to_end(input string tag);
        int n = 0;
        while (done !== 1'b1 && error !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_noerr"}, 32'(error), 0);
        check({tag, "_sysrst_lag"}, 32'(sys_resetn), 0);
        @(negedge clk);
        check({tag, "_sysrst_up"}, 32'(sys_resetn), 1);
    endtask

    // Reference: byte i of the image goes from flash FB+i to RAM RB+i, data = addr[7:0]^A5.
    task automatic verify_copy(input string tag);
        logic [23:0] fa;
        logic [15:0] ea;
        check({tag, "_nwrites"}, 32'(wa_q.size()), LEN);
        check({tag, "_nreqs"}, 32'(req_q.size()), LEN);
        for (int i = 0; i < LEN; i++) begin
            fa = FB + 24'(i);
            ea = RB + 16'(i);
            if (i < wa_q.size()) begin
                check($sformatf("%s_waddr%0d", tag, i), 32'(wa_q[i]), 32'(ea));
                check($sformatf("%s_wdata%0d", tag, i), 32'(wd_q[i]), 32'(fa[7:0] ^ 8'hA5));
            end
            if (i < req_q.size())
                check($sformatf("%s_req%0d", tag, i), 32'(req_q[i]), 32'(fa));
        end
    endtask

    initial begin
        int n;
        int bad;

        // Asynchronous reset values.
        #1 resetn = 1'b0;
        #1 check_reset_vals("rst");
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // flash_ready low for 100 cycles: nothing may happen.
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (flash_cs !== 1'b0 || ram_we !== 1'b0) bad++;
        end
        check("idle_quiet", 32'(bad), 0);

        // Copy 1: stall byte 2 for five cycles, random transfer lengths.
        stall_b2 = 1'b1;
        @(posedge clk); #1 flash_ready = 1'b1;
        n = 0;
        while (flash_cs !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("first_cs_ge3", 32'(n >= 3 && flash_cs === 1'b1), 1);
        run_to_end("copy1");
        verify_copy("copy1");
        check("copy1_b2_we_cycles", 32'(we_b2_cycles), 6);
        stall_b2 = 1'b0;

        // Copy 2: random RAM back-pressure, reset asynchronously during byte 3.
        rand_ready = 1'b1;
        do_reset();
        n = 0;
        while (!(wa_q.size() == 2 && flash_cs === 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("mid_reached_byte3", 32'(wa_q.size()), 2);
        @(posedge clk); #3 resetn = 1'b0;
        #1 check_reset_vals("midrst");
        clear_sb();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        n = 0;
        while (flash_cs !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("restart_faddr", 32'(flash_addr), 32'(FB));
        flash_ready = 1'b0;   // must be ignored once the copy has started
        run_to_end("copy2");
        verify_copy("copy2");
        rand_ready = 1'b0;
        flash_ready = 1'b1;

        // Reader never acknowledges: error 15 cycles after cs rises.
        never_busy = 1'b1;
        do_reset();
        n = 0;
        while (flash_cs !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (error !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_tmo_error", 32'(error), 1);
        check("req_tmo_latency", 32'(n), 15);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (flash_cs !== 1'b0 || done !== 1'b0 || sys_resetn !== 1'b0 ||
                ram_we !== 1'b0 || error !== 1'b1) bad++;
        end
        check("req_tmo_terminal", 32'(bad), 0);
        never_busy = 1'b0;

        // Busy stuck high: data timeout, nothing written.
        xfer_min = 200;
        xfer_max = 200;
        do_reset();
        n = 0;
        while (flash_busy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (error !== 1'b1 && n < 150) begin
            @(negedge clk);
            n++;
        end
        check("data_tmo_error", 32'(error), 1);
        check("data_tmo_latency", 32'(n >= 63 && n <= 65), 1);
        check("data_tmo_nowrite", 32'(wa_q.size()), 0);
        check("data_tmo_nodone", 32'(done), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
